// File: rtl/spi_master_pkg.sv
// Shared helpers for the SPI master: SCK half-period sizing and a counter-width check.
package spi_master_pkg;

  // Number of clk cycles in half an SCK period.
  function automatic int half_period(input int clk_div);
    return 1 << (clk_div - 1);
  endfunction

  // True when a bit counter of bcw bits can index every bit of a dw-bit word.
  function automatic bit cnt_fits(input int bcw, input int dw);
    return (64'(1) << bcw) >= 64'(dw);
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, full duplex; one DATA_WIDTH-bit word per start.
// Transfer takes a half-period setup plus DATA_WIDTH SCK periods; start is ignored while busy.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int DATA_WIDTH    = 36,
  parameter int BIT_CNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  new_data
);

  if (!cnt_fits(BIT_CNT_WIDTH, DATA_WIDTH)) begin : g_cfg_err
    $error("spi_master: BIT_CNT_WIDTH too narrow for DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HALF = 2'd1,
    ST_TRANSFER  = 2'd2
  } state_e;

  localparam logic [CLK_DIV-1:0]       CTR_HALF = CLK_DIV'(half_period(CLK_DIV) - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [CLK_DIV-1:0]       r_ctr;
  logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_mosi;
  logic                     r_new_data;

  logic w_ctr_half;
  logic w_ctr_last;
  logic w_last_bit;
  logic w_accept;

  assign w_ctr_half = (r_ctr == CTR_HALF);
  assign w_ctr_last = &r_ctr;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_accept   = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_WAIT_HALF;
      ST_WAIT_HALF: if (w_ctr_half) w_state_nxt = ST_TRANSFER;
      ST_TRANSFER:  if (w_ctr_last && w_last_bit) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // SCK is low for the first half of each bit period, so miso is captured as it rises.
  always_comb begin
    busy = (r_state != ST_IDLE);
    sck  = (r_state == ST_TRANSFER) && r_ctr[CLK_DIV-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_mosi     <= 1'b0;
      r_new_data <= 1'b0;
    end else begin
      r_new_data <= 1'b0;
      if (w_accept) begin
        r_shift   <= data_in;
        r_mosi    <= data_in[DATA_WIDTH-1];
        r_ctr     <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == ST_WAIT_HALF) begin
        r_ctr <= w_ctr_half ? '0 : r_ctr + CLK_DIV'(1);
      end else if (r_state == ST_TRANSFER) begin
        r_ctr <= r_ctr + CLK_DIV'(1);
        if (w_ctr_half) begin
          r_shift <= {r_shift[DATA_WIDTH-2:0], miso};
        end
        // Bit boundary: SCK falls here, so the next bit is launched on mosi.
        if (w_ctr_last) begin
          if (w_last_bit) begin
            r_data_out <= r_shift;
            r_new_data <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_WIDTH'(1);
            r_mosi    <= r_shift[DATA_WIDTH-1];
          end
        end
      end
    end
  end

  assign mosi     = r_mosi;
  assign data_out = r_data_out;
  assign new_data = r_new_data;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance (36-bit, CLK_DIV=2) and a small 8-bit CLK_DIV=3 instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, miso_a, mosi_a, sck_a, busy_a, nd_a;
  logic [35:0] din_a, dout_a;
  logic        loop_a, miso_fix_a;
  logic        start_b, miso_b, mosi_b, sck_b, busy_b, nd_b;
  logic [7:0]  din_b, dout_b;

  assign miso_a = loop_a ? mosi_a : miso_fix_a;
  assign miso_b = mosi_b;

  spi_master u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(din_a), .miso(miso_a),
    .mosi(mosi_a), .sck(sck_a), .data_out(dout_a), .busy(busy_a), .new_data(nd_a)
  );

  spi_master #(.CLK_DIV(3), .DATA_WIDTH(8), .BIT_CNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(din_b), .miso(miso_b),
    .mosi(mosi_b), .sck(sck_b), .data_out(dout_b), .busy(busy_b), .new_data(nd_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_nd  = 0;
  bit hold_mode = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for instance A: expected word and accept edge queued on acceptance.
  logic [35:0] exp_q_a[$];
  int          acc_q_a[$];
  logic [35:0] tx_a = '0;
  int          rises_a = 0;
  logic        sck_prev_a = 1'b0;
  bit          chk_busy_a = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q_a.delete(); acc_q_a.delete();
      rises_a = 0; sck_prev_a = 1'b0; chk_busy_a = 1'b0;
    end else begin
      if (chk_busy_a) begin
        check("a_busy_rise", 64'(busy_a), 64'(1));
        chk_busy_a = 1'b0;
      end
      if (sck_a && !sck_prev_a) begin
        if (rises_a < 36) check("a_mosi_bit", 64'(mosi_a), 64'(tx_a[35-rises_a]));
        rises_a++;
      end
      sck_prev_a = sck_a;
      if (hold_mode && !busy_a) check("a_b2b_busy_low", 64'(nd_a), 64'(1));
      if (nd_a) begin
        check("a_nd_pending", 64'(exp_q_a.size() > 0), 64'(1));
        if (exp_q_a.size() > 0) begin
          check("a_word", 64'(dout_a), 64'(exp_q_a.pop_front()));
          check("a_latency", 64'(cyc - acc_q_a.pop_front()), 64'(146));
          check("a_sck_rises", 64'(rises_a), 64'(36));
          check("a_busy_at_nd", 64'(busy_a), 64'(0));
        end
        rises_a = 0;
      end
      if (start_a && !busy_a) begin
        exp_q_a.push_back(loop_a ? din_a : {36{miso_fix_a}});
        acc_q_a.push_back(cyc + 1);
        tx_a = din_a;
        chk_busy_a = 1'b1;
      end
    end
  end

  // Scoreboard for instance B (loopback only).
  logic [7:0] exp_q_b[$];
  int         acc_q_b[$];
  int         rises_b = 0;
  int         last_rise_b = 0;
  logic       sck_prev_b = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q_b.delete(); acc_q_b.delete();
      rises_b = 0; sck_prev_b = 1'b0;
    end else begin
      if (sck_b && !sck_prev_b) begin
        if (rises_b > 0) check("b_sck_period", 64'(cyc - last_rise_b), 64'(8));
        last_rise_b = cyc;
        rises_b++;
      end
      sck_prev_b = sck_b;
      if (nd_b) begin
        check("b_nd_pending", 64'(exp_q_b.size() > 0), 64'(1));
        if (exp_q_b.size() > 0) begin
          check("b_word", 64'(dout_b), 64'(exp_q_b.pop_front()));
          check("b_latency", 64'(cyc - acc_q_b.pop_front()), 64'(68));
          check("b_sck_rises", 64'(rises_b), 64'(8));
        end
        rises_b = 0;
      end
      if (start_b && !busy_b) begin
        exp_q_b.push_back(din_b);
        acc_q_b.push_back(cyc + 1);
      end
    end
  end

  task automatic pulse_a(input logic [35:0] d);
    @(posedge clk); #1;
    din_a = d; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [7:0] d);
    @(posedge clk); #1;
    din_b = d; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_nd(input bit use_b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = use_b ? nd_b : nd_a;
    end
    check(use_b ? "b_done_timeout" : "a_done_timeout", 64'(seen), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; din_a = '0; loop_a = 1'b1; miso_fix_a = 1'b0;
    start_b = 1'b0; din_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sck_a", 64'(sck_a), 64'(0));
    check("rst_mosi_a", 64'(mosi_a), 64'(0));
    check("rst_busy_a", 64'(busy_a), 64'(0));
    check("rst_nd_a", 64'(nd_a), 64'(0));
    check("rst_dout_a", 64'(dout_a), 64'(0));
    check("rst_busy_b", 64'(busy_b), 64'(0));
    check("rst_dout_b", 64'(dout_b), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Loopback of the reference word.
    pulse_a(36'h9A5A5A5A5);
    wait_nd(1'b0);
    check("a_loopback", 64'(dout_a), 64'(36'h9A5A5A5A5));

    // miso tied high, all-zero transmit word.
    @(posedge clk); #1 loop_a = 1'b0; miso_fix_a = 1'b1;
    pulse_a(36'h0);
    wait_nd(1'b0);
    check("a_miso_ones", 64'(dout_a), 64'(36'hFFFFFFFFF));

    // A second start mid-transfer with different data is ignored.
    @(posedge clk); #1 loop_a = 1'b1;
    pulse_a(36'h123456789);
    repeat (20) @(posedge clk);
    pulse_a(36'hFEDCBA987);
    wait_nd(1'b0);
    check("a_ignore_start", 64'(dout_a), 64'(36'h123456789));

    // Reset 50 cycles into a transfer aborts it.
    pulse_a(36'h0F0F0F0F0);
    repeat (48) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_sck", 64'(sck_a), 64'(0));
    check("abort_busy", 64'(busy_a), 64'(0));
    check("abort_dout", 64'(dout_a), 64'(0));
    check("abort_nd", 64'(nd_a), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (nd_a) n_nd++;
    end
    check("a_no_nd_after_abort", 64'(n_nd), 64'(0));
    pulse_a(36'h5A5A5A5A5);
    wait_nd(1'b0);
    check("a_after_abort", 64'(dout_a), 64'(36'h5A5A5A5A5));

    // start held high: back-to-back transfers, busy drops only in the new_data cycle.
    @(posedge clk); #1 din_a = 36'h3C3C3C3C3; start_a = 1'b1;
    @(posedge clk); #1 hold_mode = 1'b1;
    repeat (3) wait_nd(1'b0);
    @(posedge clk); #1 start_a = 1'b0; hold_mode = 1'b0;
    wait_nd(1'b0);
    check("a_b2b_last", 64'(dout_a), 64'(36'h3C3C3C3C3));

    // Small instance: 8-bit words, 8-cycle SCK period.
    pulse_b(8'hC3);
    wait_nd(1'b1);
    check("b_loopback_c3", 64'(dout_b), 64'(8'hC3));
    pulse_b(8'h5E);
    wait_nd(1'b1);
    check("b_loopback_5e", 64'(dout_b), 64'(8'h5E));

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
